hub_port_guard: RTL
===================

Name: hub_port_guard

Overview:
- One instance per port, directly upstream of hub_core, between the port's PHY MII receive signals and hub_core's rx_dv/rx_er/rxd inputs.
- Enforces repeater jabber protection: a port that transmits too long is cut off until it goes quiet.
- Enforces port partitioning: a port involved in too many consecutive collisions is isolated until it sends a clean packet.
- Adds one cycle of registered latency.

Parameters:
JABBER_CYCLES, 12500, consecutive rx_dv_in cycles (50000 bit times at 4 bits/clk) after which the port is jabbered
UNJAB_CYCLES, 24, consecutive idle (rx_dv_in low) cycles required to leave jabber
PARTITION_LIMIT, 60, consecutive collided packets that partition the port
CLEAN_CYCLES, 128, minimum collision-free packet length (512 bits) that clears the count and reconnects

Ports:
clk  input  1  system clock; all MII signals synchronous to it
rst_n  input  1  asynchronous, active-low reset
rx_dv_in  input  1  PHY receive data valid
rx_er_in  input  1  PHY receive error
rxd_in  input  4  PHY receive nibble
collision  input  1  hub_core jam status (combinational in hub_core; sampled here on clk)
rx_dv  output  1  guarded data valid to hub_core
rx_er  output  1  guarded receive error to hub_core
rxd  output  4  guarded nibble to hub_core
jabber  output  1  port is in JABBER state
partitioned  output  1  port is partitioned

Behaviour:
- Reset is asynchronous and active-low. While rst_n is low: rx_dv=0, rx_er=0, rxd=0, jabber=0, partitioned=0, all counters 0, FSM in WAIT_IDLE.
- Forwarding path: rx_dv, rx_er and rxd are registered copies of the inputs, one clk of latency.
  - rx_dv=rx_dv_in & fwd, where fwd is true only in ACTIVE state with the port not partitioned.
  - rx_er=rx_er_in & fwd.
  - rxd=rxd_in when fwd, else 0.
- Main FSM:
  - WAIT_IDLE: entered on reset. Go to IDLE on the first cycle rx_dv_in=0. This prevents forwarding a fragment when reset is released mid-packet.
  - IDLE: on rx_dv_in=1, go to ACTIVE. Clear the length counter and col_seen. Latch fwd for the whole packet from the current partition state.
  - ACTIVE: length counter increments each cycle, saturating. col_seen is set if collision=1 on any cycle with rx_dv_in=1.
    - If rx_dv_in=0: end of packet; go to IDLE and apply the partition update below.
    - If the length counter reaches JABBER_CYCLES with rx_dv_in still 1: go to JABBER. No partition update occurs.
  - JABBER: jabber=1; rx_dv is forced to 0 from the next registered output. The unjab counter counts consecutive cycles with rx_dv_in=0 and resets to 0 on any rx_dv_in=1. At UNJAB_CYCLES, go to IDLE and drop jabber.
- Partition update, at end of packet in ACTIVE only:
  - If col_seen: col_count increments, saturating at PARTITION_LIMIT. When col_count reaches PARTITION_LIMIT, partitioned=1.
  - Else if length ≥ CLEAN_CYCLES: col_count=0 and partitioned=0.
  - Else (short packet, no collision): no change.
- Partition changes take effect only at the next packet start; a packet in flight is never truncated by partitioning.
- A partitioned port is still monitored (FSM and jabber still run); only forwarding is suppressed.
- Simultaneous events:
  - rx_dv_in falling on the same cycle the length counter reaches JABBER_CYCLES: treated as end of packet. No jabber.
  - collision on the last rx_dv_in=1 cycle counts toward col_seen.
- Counter widths are $clog2 of (parameter+1). All counters saturate and never wrap.

Optional Feature:
- Macro: HUB_PORT_GUARD_STATS_EN.
- When defined, two extra outputs are added:
  - jabber_events [15:0]: increments on each ACTIVE→JABBER transition.
  - partition_events [15:0]: increments on each partitioned 0→1 transition.
  - Both saturate at 16'hffff and reset to 0.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Bench overrides: JABBER_CYCLES=100, UNJAB_CYCLES=8, PARTITION_LIMIT=3, CLEAN_CYCLES=16.
- Clean 20-cycle packet, rxd counting 0..F → identical rx_dv/rxd stream 1 clk later; jabber=0, partitioned=0.
- 150-cycle continuous rx_dv_in → rx_dv high for exactly 100 cycles, then 0 with jabber=1. rx_dv_in low 5 cycles, high 1, low 8 → jabber drops after the final 8th idle cycle. Next packet forwards.
- Three 10-cycle packets each with collision pulsed at cycle 4 → partitioned=1 after the third packet ends. Fourth 20-cycle clean packet → rx_dv stays 0 throughout, partitioned clears at its end. Fifth packet forwards.
- Partitioned port sends a 10-cycle clean packet (< CLEAN_CYCLES) → stays partitioned, not forwarded.
- Assert rst_n low during cycle 5 of a 30-cycle packet, release at cycle 8 → outputs 0 immediately; nothing forwarded until rx_dv_in drops; the next packet forwards normally.
- With HUB_PORT_GUARD_STATS_EN: run the jabber test twice and the partition test once → jabber_events=2, partition_events=1.

Source files
------------

// File: rtl/hub_port_guard.sv
// hub_port_guard: per-port jabber and partition guard in front of hub_core.
// Ports: clk, rst_n (async low); rx_dv_in/rx_er_in/rxd_in from PHY;
// collision from hub_core; rx_dv/rx_er/rxd guarded copies (1 clk later);
// jabber, partitioned status. Optional macro HUB_PORT_GUARD_STATS_EN
// adds jabber_events/partition_events saturating 16-bit counters.
module hub_port_guard #(
   parameter int JABBER_CYCLES   = 12500,
   parameter int UNJAB_CYCLES    = 24,
   parameter int PARTITION_LIMIT = 60,
   parameter int CLEAN_CYCLES    = 128
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_dv_in,
   input  logic       rx_er_in,
   input  logic [3:0] rxd_in,
   input  logic       collision,
   output logic       rx_dv,
   output logic       rx_er,
   output logic [3:0] rxd,
   output logic       jabber,
   output logic       partitioned
`ifdef HUB_PORT_GUARD_STATS_EN
   ,
   output logic [15:0] jabber_events,
   output logic [15:0] partition_events
`endif
);

   localparam int LW = $clog2(JABBER_CYCLES + 1);
   localparam int UW = $clog2(UNJAB_CYCLES + 1);
   localparam int CW = $clog2(PARTITION_LIMIT + 1);

   localparam logic [LW-1:0] LEN_MAX = LW'(JABBER_CYCLES);
   localparam logic [UW-1:0] UNJ_MAX = UW'(UNJAB_CYCLES);
   localparam logic [CW-1:0] COL_MAX = CW'(PARTITION_LIMIT);

   typedef enum logic [1:0] {
      S_WAIT_IDLE,
      S_IDLE,
      S_ACTIVE,
      S_JABBER
   } state_t;

   state_t        state_q;
   logic [LW-1:0] len_q;
   logic [UW-1:0] unjab_q;
   logic [CW-1:0] col_q;
   logic          col_seen_q;
   logic          fwd_q;
   logic          jabber_q;
   logic          part_q;
   logic          rx_dv_q;
   logic          rx_er_q;
   logic [3:0]    rxd_q;

   logic          start;
   logic          jab_hit;
   logic          fwd_now;
   logic [LW-1:0] len_d;
   logic [UW-1:0] unjab_d;
   logic [CW-1:0] col_d;

   assign start   = (state_q == S_IDLE) && rx_dv_in;
   assign jab_hit = (state_q == S_ACTIVE) && rx_dv_in && (len_q == LEN_MAX);

   // The first nibble is seen while still in IDLE, so the packet's
   // forwarding decision is taken combinationally on that cycle and then
   // held in fwd_q for the rest of the packet.
   assign fwd_now = start ? !part_q
                          : ((state_q == S_ACTIVE) && fwd_q && !jab_hit);

   assign len_d   = (len_q == LEN_MAX) ? len_q : len_q + LW'(1);
   assign unjab_d = (unjab_q == UNJ_MAX) ? unjab_q : unjab_q + UW'(1);
   assign col_d   = (col_q == COL_MAX) ? col_q : col_q + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_WAIT_IDLE;
         len_q      <= '0;
         unjab_q    <= '0;
         col_q      <= '0;
         col_seen_q <= 1'b0;
         fwd_q      <= 1'b0;
         jabber_q   <= 1'b0;
         part_q     <= 1'b0;
         rx_dv_q    <= 1'b0;
         rx_er_q    <= 1'b0;
         rxd_q      <= '0;
      end else begin
         rx_dv_q <= rx_dv_in & fwd_now;
         rx_er_q <= rx_er_in & fwd_now;
         rxd_q   <= fwd_now ? rxd_in : 4'h0;
         case (state_q)
            S_WAIT_IDLE: begin
               if (!rx_dv_in) state_q <= S_IDLE;
            end
            S_IDLE: begin
               if (rx_dv_in) begin
                  state_q    <= S_ACTIVE;
                  len_q      <= LW'(1);
                  col_seen_q <= collision;
                  fwd_q      <= !part_q;
               end
            end
            S_ACTIVE: begin
               if (!rx_dv_in) begin
                  state_q <= S_IDLE;
                  if (col_seen_q) begin
                     col_q <= col_d;
                     if (col_d == COL_MAX) part_q <= 1'b1;
                  end else if (32'(len_q) >= CLEAN_CYCLES) begin
                     col_q  <= '0;
                     part_q <= 1'b0;
                  end
               end else if (len_q == LEN_MAX) begin
                  state_q  <= S_JABBER;
                  jabber_q <= 1'b1;
                  unjab_q  <= '0;
               end else begin
                  len_q <= len_d;
                  if (collision) col_seen_q <= 1'b1;
               end
            end
            S_JABBER: begin
               if (rx_dv_in) begin
                  unjab_q <= '0;
               end else if (unjab_d == UNJ_MAX) begin
                  state_q  <= S_IDLE;
                  jabber_q <= 1'b0;
                  unjab_q  <= '0;
               end else begin
                  unjab_q <= unjab_d;
               end
            end
            default: state_q <= S_WAIT_IDLE;
         endcase
      end
   end

   assign rx_dv       = rx_dv_q;
   assign rx_er       = rx_er_q;
   assign rxd         = rxd_q;
   assign jabber      = jabber_q;
   assign partitioned = part_q;

`ifdef HUB_PORT_GUARD_STATS_EN
   logic        part_set;
   logic [15:0] jev_q;
   logic [15:0] pev_q;

   assign part_set = (state_q == S_ACTIVE) && !rx_dv_in && col_seen_q
                     && (col_d == COL_MAX) && !part_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jev_q <= '0;
         pev_q <= '0;
      end else begin
         if (jab_hit && jev_q != 16'hffff) jev_q <= jev_q + 16'd1;
         if (part_set && pev_q != 16'hffff) pev_q <= pev_q + 16'd1;
      end
   end

   assign jabber_events    = jev_q;
   assign partition_events = pev_q;
`endif

endmodule
